// File: rtl/arb_seq_checker.sv
// Monitor for the 0,1,2,3,6,5,7 arbitrary-sequence counter: acquires lock,
// flywheels through the pattern, and flags mismatches, illegal 4s and periods.
module arb_seq_checker #(
  parameter int LOCK_COUNT   = 7,
  parameter int UNLOCK_COUNT = 3,
  parameter int ERR_W        = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [2:0]       seq_in,
  input  logic             seq_valid,
  output logic             locked,
  output logic [2:0]       expected,
  output logic             mismatch,
  output logic             illegal,
  output logic             period_done,
  output logic [ERR_W-1:0] err_count
);

  localparam logic [1:0] ST_SEARCH  = 2'd0;
  localparam logic [1:0] ST_ACQUIRE = 2'd1;
  localparam logic [1:0] ST_LOCKED  = 2'd2;

  localparam int               MISS_W     = $clog2(UNLOCK_COUNT + 1);
  localparam logic [2:0]       LOCK_LIM   = 3'(LOCK_COUNT);
  localparam logic [MISS_W:0]  UNLOCK_LIM = (MISS_W + 1)'(UNLOCK_COUNT);
  localparam logic [ERR_W-1:0] ERR_MAX    = '1;

  function automatic logic [2:0] table_val(input logic [2:0] i);
    case (i)
      3'd0:    table_val = 3'd0;
      3'd1:    table_val = 3'd1;
      3'd2:    table_val = 3'd2;
      3'd3:    table_val = 3'd3;
      3'd4:    table_val = 3'd6;
      3'd5:    table_val = 3'd5;
      3'd6:    table_val = 3'd7;
      default: table_val = 3'd0;
    endcase
  endfunction

  function automatic logic [2:0] idx_next(input logic [2:0] i);
    idx_next = (i == 3'd6) ? 3'd0 : i + 3'd1;
  endfunction

  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    sat_inc = (v == ERR_MAX) ? v : v + 1'b1;
  endfunction

  logic [1:0]        state_q, state_d;
  logic [2:0]        idx_q, idx_d;
  logic [2:0]        run_q, run_d;
  logic [MISS_W-1:0] miss_q, miss_d;
  logic [ERR_W-1:0]  err_count_q, err_count_d;
  logic              locked_q, locked_d;
  logic [2:0]        expected_q, expected_d;
  logic              mismatch_q, mismatch_d;
  logic              illegal_q, illegal_d;
  logic              period_done_q, period_done_d;
  logic              hit;
  logic [2:0]        run_inc;
  logic [MISS_W:0]   miss_inc;

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    run_d         = run_q;
    miss_d        = miss_q;
    err_count_d   = err_count_q;
    mismatch_d    = 1'b0;
    illegal_d     = 1'b0;
    period_done_d = 1'b0;
    hit           = (seq_in == table_val(idx_q));
    run_inc       = run_q + 3'd1;
    miss_inc      = {1'b0, miss_q} + 1'b1;

    if (seq_valid) begin
      illegal_d = (seq_in == 3'd4);
      case (state_q)
        ST_SEARCH: begin
          if (seq_in == 3'd0) begin
            idx_d = 3'd1;
            if (LOCK_COUNT == 1) begin
              state_d = ST_LOCKED;
              miss_d  = '0;
            end else begin
              state_d = ST_ACQUIRE;
              run_d   = 3'd1;
            end
          end
        end
        ST_ACQUIRE: begin
          if (hit) begin
            idx_d = idx_next(idx_q);
            run_d = run_inc;
            if (run_inc == LOCK_LIM) begin
              state_d       = ST_LOCKED;
              miss_d        = '0;
              period_done_d = (idx_q == 3'd6);
            end
          end else if (seq_in == 3'd0) begin
            idx_d = 3'd1;
            run_d = 3'd1;
          end else begin
            state_d = ST_SEARCH;
            idx_d   = 3'd0;
            run_d   = 3'd0;
          end
        end
        ST_LOCKED: begin
          // Flywheel: the index advances whether or not the sample matched.
          idx_d = idx_next(idx_q);
          if (hit) begin
            miss_d        = '0;
            period_done_d = (idx_q == 3'd6);
          end else begin
            mismatch_d  = 1'b1;
            err_count_d = sat_inc(err_count_q);
            miss_d      = miss_inc[MISS_W-1:0];
            if (miss_inc == UNLOCK_LIM) begin
              state_d = ST_SEARCH;
              idx_d   = 3'd0;
              run_d   = 3'd0;
              miss_d  = '0;
            end
          end
        end
        default: begin
          state_d = ST_SEARCH;
          idx_d   = 3'd0;
          run_d   = 3'd0;
          miss_d  = '0;
        end
      endcase
    end

    locked_d   = (state_d == ST_LOCKED);
    expected_d = locked_d ? table_val(idx_d) : 3'd0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= ST_SEARCH;
      idx_q         <= 3'd0;
      run_q         <= 3'd0;
      miss_q        <= '0;
      err_count_q   <= '0;
      locked_q      <= 1'b0;
      expected_q    <= 3'd0;
      mismatch_q    <= 1'b0;
      illegal_q     <= 1'b0;
      period_done_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      run_q         <= run_d;
      miss_q        <= miss_d;
      err_count_q   <= err_count_d;
      locked_q      <= locked_d;
      expected_q    <= expected_d;
      mismatch_q    <= mismatch_d;
      illegal_q     <= illegal_d;
      period_done_q <= period_done_d;
    end
  end

  assign locked      = locked_q;
  assign expected    = expected_q;
  assign mismatch    = mismatch_q;
  assign illegal     = illegal_q;
  assign period_done = period_done_q;
  assign err_count   = err_count_q;

endmodule

// File: tb/tb_arb_seq_checker.sv
// Bench for arb_seq_checker: a default instance and an ERR_W=2/UNLOCK_COUNT=7
// instance share directed and random stimulus against an abstract model.
module tb_arb_seq_checker;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] seq_in = 3'd0;
  logic       seq_valid = 1'b0;

  logic       locked0, mismatch0, illegal0, period_done0;
  logic [2:0] expected0;
  logic [7:0] err_count0;
  logic       locked1, mismatch1, illegal1, period_done1;
  logic [2:0] expected1;
  logic [1:0] err_count1;

  always #5 clock = ~clock;

  arb_seq_checker dut0 (
    .clock(clock), .reset(reset), .seq_in(seq_in), .seq_valid(seq_valid),
    .locked(locked0), .expected(expected0), .mismatch(mismatch0),
    .illegal(illegal0), .period_done(period_done0), .err_count(err_count0)
  );

  arb_seq_checker #(.LOCK_COUNT(7), .UNLOCK_COUNT(7), .ERR_W(2)) dut1 (
    .clock(clock), .reset(reset), .seq_in(seq_in), .seq_valid(seq_valid),
    .locked(locked1), .expected(expected1), .mismatch(mismatch1),
    .illegal(illegal1), .period_done(period_done1), .err_count(err_count1)
  );

  int TBL [7] = '{0, 1, 2, 3, 6, 5, 7};
  int p_lock [2] = '{7, 7};
  int p_unlock [2] = '{3, 7};
  int p_emax [2] = '{255, 3};

  // Model: mode 0=hunting, 1=confirming, 2=locked
  int m_mode [2], m_pos [2], m_run [2], m_miss [2], m_err [2];
  int e_locked [2], e_exp [2], e_mm [2], e_ill [2], e_pd [2];

  int n_chk = 0;
  int n_fail = 0;
  int gen_pos = 0;

  task automatic model_step(input int m, input bit v, input int s, input bit r);
    bit hit;
    if (r) begin
      m_mode[m] = 0; m_pos[m] = 0; m_run[m] = 0; m_miss[m] = 0; m_err[m] = 0;
      e_mm[m] = 0; e_ill[m] = 0; e_pd[m] = 0;
    end else if (!v) begin
      e_mm[m] = 0; e_ill[m] = 0; e_pd[m] = 0;
    end else begin
      e_ill[m] = (s == 4);
      e_mm[m] = 0;
      e_pd[m] = 0;
      hit = (s == TBL[m_pos[m]]);
      if (m_mode[m] == 0) begin
        if (s == 0) begin
          m_pos[m] = 1;
          if (p_lock[m] == 1) begin m_mode[m] = 2; m_miss[m] = 0; end
          else begin m_mode[m] = 1; m_run[m] = 1; end
        end
      end else if (m_mode[m] == 1) begin
        if (hit) begin
          m_run[m]++;
          if (m_run[m] == p_lock[m]) begin
            m_mode[m] = 2; m_miss[m] = 0; e_pd[m] = (m_pos[m] == 6);
          end
          m_pos[m] = (m_pos[m] + 1) % 7;
        end else if (s == 0) begin
          m_pos[m] = 1; m_run[m] = 1;
        end else begin
          m_mode[m] = 0; m_pos[m] = 0; m_run[m] = 0;
        end
      end else begin
        e_pd[m] = hit && (m_pos[m] == 6);
        m_pos[m] = (m_pos[m] + 1) % 7;
        if (hit) m_miss[m] = 0;
        else begin
          e_mm[m] = 1;
          m_err[m] = (m_err[m] + 1 > p_emax[m]) ? p_emax[m] : m_err[m] + 1;
          m_miss[m]++;
          if (m_miss[m] == p_unlock[m]) begin
            m_mode[m] = 0; m_pos[m] = 0; m_run[m] = 0; m_miss[m] = 0;
          end
        end
      end
    end
    e_locked[m] = (m_mode[m] == 2);
    e_exp[m] = e_locked[m] ? TBL[m_pos[m]] : 0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s at %0t: observed=%0d expected=%0d", tag, $time, obs, exp_v);
    end
  endtask

  task automatic check_all();
    chk("d0.locked", {31'd0, locked0}, e_locked[0]);
    chk("d0.expected", {29'd0, expected0}, e_exp[0]);
    chk("d0.mismatch", {31'd0, mismatch0}, e_mm[0]);
    chk("d0.illegal", {31'd0, illegal0}, e_ill[0]);
    chk("d0.period_done", {31'd0, period_done0}, e_pd[0]);
    chk("d0.err_count", {24'd0, err_count0}, m_err[0]);
    chk("d1.locked", {31'd0, locked1}, e_locked[1]);
    chk("d1.expected", {29'd0, expected1}, e_exp[1]);
    chk("d1.mismatch", {31'd0, mismatch1}, e_mm[1]);
    chk("d1.illegal", {31'd0, illegal1}, e_ill[1]);
    chk("d1.period_done", {31'd0, period_done1}, e_pd[1]);
    chk("d1.err_count", {30'd0, err_count1}, m_err[1]);
  endtask

  task automatic step(input bit v, input int s, input bit r);
    seq_valid = v;
    seq_in = 3'(s);
    reset = r;
    @(posedge clock);
    model_step(0, v, s, r);
    model_step(1, v, s, r);
    #1;
    check_all();
  endtask

  task automatic good(input int n);
    for (int i = 0; i < n; i++) begin
      step(1'b1, TBL[gen_pos], 1'b0);
      gen_pos = (gen_pos + 1) % 7;
    end
  endtask

  task automatic bad(input int s);
    step(1'b1, s, 1'b0);
    gen_pos = (gen_pos + 1) % 7;
  endtask

  initial begin
    int s;
    bit v;
    step(1'b0, 0, 1'b1);
    step(1'b1, 0, 1'b1);
    step(1'b0, 5, 1'b0);

    // Clean stream: lock after the first 7, then a period every 7 samples
    gen_pos = 0;
    good(21);
    chk("lock_after_3_periods", {31'd0, locked0}, 32'd1);

    // Single corrupted sample (4 in place of 6)
    good(4);
    bad(4);
    good(16);

    // Three consecutive wrong samples in place of 3,6,5
    good(3);
    bad(1); bad(1); bad(1);
    chk("unlock_after_3_misses", {31'd0, locked0}, 32'd0);
    good(1);
    good(21);

    // Entry mid-pattern
    step(1'b1, 0, 1'b1);
    gen_pos = 3;
    good(18);

    // seq_valid toggling every cycle
    step(1'b0, 0, 1'b1);
    gen_pos = 0;
    for (int i = 0; i < 21; i++) begin
      step(1'b1, TBL[gen_pos], 1'b0);
      gen_pos = (gen_pos + 1) % 7;
      step(1'b0, int'($urandom_range(0, 7)), 1'b0);
    end

    // Continuous errors while locked, then reset mid-operation
    step(1'b0, 0, 1'b1);
    gen_pos = 0;
    good(7);
    for (int i = 0; i < 6; i++) bad((TBL[gen_pos] + 1) % 8);
    good(8);
    chk("sat_err_count", {30'd0, err_count1}, 32'd3);
    step(1'b1, TBL[gen_pos], 1'b1);
    step(1'b0, 0, 1'b0);
    chk("reset_clears_lock", {31'd0, locked1}, 32'd0);

    // Random: mostly-correct stream with corruption, slips and idle cycles
    gen_pos = 0;
    for (int i = 0; i < 600; i++) begin
      v = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 9) == 0) s = int'($urandom_range(0, 7));
      else s = TBL[gen_pos];
      if ($urandom_range(0, 79) == 0) gen_pos = int'($urandom_range(0, 6));
      step(v, s, ($urandom_range(0, 299) == 0));
      if (v) gen_pos = (gen_pos + 1) % 7;
    end

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule

// File: doc/arb_seq_checker.md
Name: arb_seq_checker

Overview:
- Downstream monitor for the 3-bit arbitrary-sequence counter output.
- The expected repeating sequence is 0,1,2,3,6,5,7; the value 4 never occurs.
- The block acquires lock on the stream, then tracks each sample against the expected pattern with flywheel indexing, so one bad sample does not lose alignment.
- It reports mismatches, illegal values and completed periods, and keeps a saturating error count for self-check and BIST logging.

Parameters:
- LOCK_COUNT, 7: consecutive matching samples, starting from a 0, required to declare lock. Legal range 1..7.
- UNLOCK_COUNT, 3: consecutive mismatches while locked that force loss of lock. Minimum 1.
- ERR_W, 8: width of err_count.

Ports:
- clock, input, 1: system clock, rising-edge.
- reset, input, 1: synchronous, active-high.
- seq_in, input, 3: sample from the sequence generator.
- seq_valid, input, 1: seq_in is sampled only when high. Tie high for a free-running generator.
- locked, output, 1: checker is aligned to the sequence.
- expected, output, 3: value predicted for the next valid sample. Equals 0 when not locked.
- mismatch, output, 1: 1-cycle pulse; the last valid sample taken while locked differed from the prediction.
- illegal, output, 1: 1-cycle pulse; the last valid sample was 4, in any state.
- period_done, output, 1: 1-cycle pulse; a matching 7 completed a period and the block is locked after that sample.
- err_count, output, ERR_W: total locked-state mismatches, saturating.

Behaviour:
- Interface: clock is clock. reset is reset, synchronous, active-high.
- All outputs are registered. A response appears in the cycle after the edge on which seq_valid=1 was sampled (1-cycle latency).
- Reset values: locked=0, expected=0, mismatch=0, illegal=0, period_done=0, err_count=0. Internal state is SEARCH, with idx=0, run=0 and miss=0.
- A reset asserted mid-operation clears everything at that edge, whatever seq_valid is.
- Expected table (idx 0..6): 0,1,2,3,6,5,7. idx wraps from 6 to 0.
- When seq_valid=0: state, idx, counters and expected all hold, and the pulse outputs are 0.
- illegal pulses for any valid seq_in==4, independent of state.
- SEARCH state:
  - A valid 0 moves to ACQUIRE with idx=1, run=1.
  - If LOCK_COUNT==1, a valid 0 goes directly to LOCKED.
  - Any other value stays in SEARCH.
- ACQUIRE state, on each valid sample:
  - If seq_in==table[idx]: idx advances, run increments. When run reaches LOCK_COUNT, go to LOCKED with miss=0.
  - If seq_in does not match and seq_in==0: restart with idx=1, run=1, staying in ACQUIRE.
  - Otherwise, on a mismatch: go to SEARCH, run=0.
  - mismatch and err_count are not affected in ACQUIRE.
- LOCKED state, on each valid sample:
  - idx always advances (flywheel).
  - On a match, miss clears.
  - On a mismatch: mismatch pulses, err_count increments (saturating at 2^ERR_W-1, with no wrap), and miss increments.
  - When miss reaches UNLOCK_COUNT: go to SEARCH, locked=0, run=0, miss=0. The sample that causes this still counts as an error.
- expected equals table[idx] while locked, else 0.
- period_done pulses when a valid 7 matches at idx=6 and the resulting state is LOCKED. This includes the sample that achieves lock when lock completes on a 7.
- locked rises in the cycle after the LOCK_COUNT-th matching sample, and falls in the cycle after the UNLOCK_COUNT-th consecutive miss.
- seq_in is never trusted to re-align while locked. Re-alignment happens only through SEARCH.

Test Plan:
- Defaults. Reset, then seq_valid=1 with the stream 0,1,2,3,6,5,7 repeating → locked=1 in the cycle after the 1st "7". period_done pulses then and every 7 cycles after. err_count=0, mismatch never asserted.
- Locked stream with one sample corrupted (4 instead of 6) → mismatch=1 and illegal=1 for one cycle, err_count=1, locked stays 1. The following 5 matches with no mismatch, and expected shows the correct prediction at each step.
- Locked stream with three consecutive wrong samples (1,1,1 in place of 3,6,5) → err_count=3, locked=0 in the cycle after the third. After the next 0, re-lock occurs 7 matching samples later.
- Entry mid-pattern (3,6,5,7,0,1,2,3,6,5,7) → stays in SEARCH through the first four samples. locked=1 after the second 7; no mismatch pulses.
- seq_valid toggling 1/0 every cycle on a correct stream → lock is still reached after 7 valid samples. Outputs hold and pulses stay 0 on invalid cycles.
- ERR_W=2 with continuous errors while locked and UNLOCK_COUNT=7 → err_count saturates at 3. Reset asserted while locked returns all outputs to 0 in the next cycle.
